// File: rtl/acc_cpu_pkg.sv
// Shared state, opcode and sub-code encodings for the parametrised accumulator CPU.
package acc_cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_OPERAND,
    ST_EXEC,
    ST_HALT,
    ST_STALL
  } state_t;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_LDI    = 4'h1;
  localparam logic [3:0] OP_ADDI   = 4'h2;
  localparam logic [3:0] OP_SUBI   = 4'h3;
  localparam logic [3:0] OP_ANDI   = 4'h4;
  localparam logic [3:0] OP_ORI    = 4'h5;
  localparam logic [3:0] OP_XORI   = 4'h6;
  localparam logic [3:0] OP_MOV    = 4'h7;
  localparam logic [3:0] OP_LD     = 4'h8;
  localparam logic [3:0] OP_ADD    = 4'h9;
  localparam logic [3:0] OP_SUB    = 4'hA;
  localparam logic [3:0] OP_UNARY  = 4'hB;
  localparam logic [3:0] OP_BRANCH = 4'hC;
  localparam logic [3:0] OP_HALT   = 4'hF;

  localparam logic [3:0] U_NOT = 4'h0;
  localparam logic [3:0] U_SHL = 4'h1;
  localparam logic [3:0] U_SHR = 4'h2;
  localparam logic [3:0] U_INC = 4'h3;
  localparam logic [3:0] U_DEC = 4'h4;

  localparam logic [3:0] BR_JMP = 4'h0;
  localparam logic [3:0] BR_JZ  = 4'h1;
  localparam logic [3:0] BR_JNZ = 4'h2;
  localparam logic [3:0] BR_JC  = 4'h3;
  localparam logic [3:0] BR_JNC = 4'h4;

  // Immediate ALU ops and branches carry a second word.
  function automatic logic is_two_word(input logic [3:0] opcode);
    return ((opcode >= OP_LDI) && (opcode <= OP_XORI)) || (opcode == OP_BRANCH);
  endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational ALU: computes the accumulator result and Z/C flags for one opcode.
module acc_cpu_alu #(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [3:0]        sub,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              c_in,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              c,
  output logic              writes_ac
);
  import acc_cpu_pkg::*;

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;
  logic [DATA_W:0] inc;
  logic [DATA_W:0] dec;

  // The extra top bit is carry for additions and borrow for subtractions.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign inc  = {1'b0, a} + {{DATA_W{1'b0}}, 1'b1};
  assign dec  = {1'b0, a} - {{DATA_W{1'b0}}, 1'b1};

  always_comb begin
    result    = a;
    c         = c_in;
    writes_ac = 1'b1;
    case (op)
      OP_LDI, OP_LD:   result = b;
      OP_ADDI, OP_ADD: {c, result} = sum;
      OP_SUBI, OP_SUB: {c, result} = diff;
      OP_ANDI: begin
        result = a & b;
        c      = 1'b0;
      end
      OP_ORI: begin
        result = a | b;
        c      = 1'b0;
      end
      OP_XORI: begin
        result = a ^ b;
        c      = 1'b0;
      end
      OP_UNARY: begin
        case (sub)
          U_NOT: begin
            result = ~a;
            c      = 1'b0;
          end
          U_SHL: begin
            result = {a[DATA_W-2:0], 1'b0};
            c      = a[DATA_W-1];
          end
          U_SHR: begin
            result = {1'b0, a[DATA_W-1:1]};
            c      = a[0];
          end
          U_INC:   {c, result} = inc;
          U_DEC:   {c, result} = dec;
          default: writes_ac = 1'b0;
        endcase
      end
      default: writes_ac = 1'b0;
    endcase
  end

  assign z = (result == '0);

endmodule

// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: program memory, register file, PC and FETCH/OPERAND/EXEC control.
// Define ACC_CPU_STEP_EN to add step/step_mode inputs for one-instruction-per-pulse execution.
module acc_cpu_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              start,
`ifdef ACC_CPU_STEP_EN
  input  logic              step,
  input  logic              step_mode,
`endif
  output logic              busy,
  output logic              halted,
  output logic              err,
  output logic [DATA_W-1:0] acc_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              flag_z,
  output logic              flag_c
);
  import acc_cpu_pkg::*;

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] imem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ac_q, ac_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [7:0]        ir_q, ir_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic              z_q, z_d, c_q, c_d, err_q, err_d;
  logic              busy_q, halted_q;

  logic [3:0]        op, sub;
  logic [DATA_W-1:0] fetch_word, reg_b, alu_b, alu_result;
  logic              alu_z, alu_c, alu_writes;
  logic              illegal, take_branch, idle_like, step_go;
  state_t            run_state;

  assign op         = ir_q[7:4];
  assign sub        = ir_q[3:0];
  assign fetch_word = imem[pc_q];
  assign idle_like  = (state_q == ST_IDLE) || (state_q == ST_HALT);

`ifdef ACC_CPU_STEP_EN
  assign run_state = step_mode ? ST_STALL : ST_FETCH;
  assign step_go   = step | ~step_mode;
`else
  assign run_state = ST_FETCH;
  assign step_go   = 1'b1;
`endif

  // Program loads are locked out while an instruction is in flight.
  always_ff @(posedge clk) begin
    if (prog_we && idle_like) imem[prog_addr] <= prog_data;
  end

  always_comb begin
    reg_b = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (sub == 4'(i)) reg_b = regs_q[i];
    end
  end

  assign alu_b = is_two_word(op) ? imm_q : reg_b;

  acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op       (op),
    .sub      (sub),
    .a        (ac_q),
    .b        (alu_b),
    .c_in     (c_q),
    .result   (alu_result),
    .z        (alu_z),
    .c        (alu_c),
    .writes_ac(alu_writes)
  );

  always_comb begin
    illegal = 1'b0;
    case (op)
      OP_MOV, OP_LD, OP_ADD, OP_SUB: illegal = (32'(sub) >= NREGS);
      OP_UNARY:                      illegal = (sub > U_DEC);
      OP_BRANCH:                     illegal = (sub > BR_JNC);
      4'hD, 4'hE:                    illegal = 1'b1;
      default:                       illegal = 1'b0;
    endcase
  end

  always_comb begin
    case (sub)
      BR_JMP:  take_branch = 1'b1;
      BR_JZ:   take_branch = z_q;
      BR_JNZ:  take_branch = ~z_q;
      BR_JC:   take_branch = c_q;
      BR_JNC:  take_branch = ~c_q;
      default: take_branch = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ac_d    = ac_q;
    imm_d   = imm_q;
    ir_d    = ir_q;
    regs_d  = regs_q;
    z_d     = z_q;
    c_d     = c_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          pc_d    = '0;
          err_d   = 1'b0;
          state_d = run_state;
        end
      end
      ST_STALL: begin
        if (step_go) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        ir_d    = fetch_word[7:0];
        pc_d    = pc_q + ADDR_W'(1);
        state_d = is_two_word(fetch_word[7:4]) ? ST_OPERAND : ST_EXEC;
      end
      ST_OPERAND: begin
        imm_d   = fetch_word;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        // A trapped instruction leaves every architectural register untouched.
        if (illegal) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end else if (op == OP_HALT) begin
          state_d = ST_HALT;
        end else begin
          if (alu_writes) begin
            ac_d = alu_result;
            z_d  = alu_z;
            c_d  = alu_c;
          end
          if (op == OP_MOV) begin
            for (int i = 0; i < NREGS; i++) begin
              if (sub == 4'(i)) regs_d[i] = ac_q;
            end
          end
          if ((op == OP_BRANCH) && take_branch) pc_d = imm_q[ADDR_W-1:0];
          state_d = run_state;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      ac_q     <= '0;
      imm_q    <= '0;
      ir_q     <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ac_q     <= ac_d;
      imm_q    <= imm_d;
      ir_q     <= ir_d;
      z_q      <= z_d;
      c_q      <= c_d;
      err_q    <= err_d;
      busy_q   <= (state_d == ST_FETCH) || (state_d == ST_OPERAND) || (state_d == ST_EXEC);
      halted_q <= (state_d == ST_HALT);
      regs_q   <= regs_d;
    end
  end

  assign busy    = busy_q;
  assign halted  = halted_q;
  assign err     = err_q;
  assign acc_out = ac_q;
  assign pc_out  = pc_q;
  assign flag_z  = z_q;
  assign flag_c  = c_q;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Testbench for acc_cpu_core with an instruction-level reference model and directed programs.
// Step-mode programs are exercised only when ACC_CPU_STEP_EN is defined.
module tb_acc_cpu_core;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 4;

  logic       clk;
  logic       rst, prog_we, start, step, step_mode;
  logic [4:0] prog_addr;
  logic [7:0] prog_data;
  logic       busy, halted, err, flag_z, flag_c;
  logic [7:0] acc_out;
  logic [4:0] pc_out;

  int checks = 0;
  int errors = 0;

  acc_cpu_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) dut (
    .clk      (clk),
    .rst      (rst),
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .start    (start),
`ifdef ACC_CPU_STEP_EN
    .step     (step),
    .step_mode(step_mode),
`endif
    .busy     (busy),
    .halted   (halted),
    .err      (err),
    .acc_out  (acc_out),
    .pc_out   (pc_out),
    .flag_z   (flag_z),
    .flag_c   (flag_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference machine state: whole instructions, memory and architectural registers.
  logic [7:0] mem [32];
  logic [7:0] m_regs [4];
  logic [7:0] m_ac;
  logic [4:0] m_pc, m_ipc;
  logic       m_z, m_c, m_err, m_run, m_halt, m_stall;
  int         m_phase, m_len;

  logic       s_rst, s_we, s_start, s_step, s_mode;
  logic [4:0] s_addr;
  logic [7:0] s_data;

  always @(posedge clk) begin
    s_rst   <= rst;
    s_we    <= prog_we;
    s_start <= start;
    s_step  <= step;
    s_mode  <= step_mode;
    s_addr  <= prog_addr;
    s_data  <= prog_data;
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
  end

  function automatic bit twoWord(input logic [3:0] opc);
    return (opc >= 4'h1 && opc <= 4'h6) || opc == 4'hC;
  endfunction

  task automatic setAcc(input int v, input bit cy);
    m_ac = v[7:0];
    m_z  = (m_ac == 8'h00);
    m_c  = cy;
  endtask

  task automatic loadAcc(input logic [7:0] v);
    m_ac = v;
    m_z  = (v == 8'h00);
  endtask

  task automatic execute();
    logic [7:0] w, imm;
    int a, iv, n, r;
    bit ill, hlt, take;
    w    = mem[m_ipc];
    imm  = mem[m_ipc + 5'd1];
    a    = m_ac;
    iv   = imm;
    n    = w[3:0];
    r    = 0;
    ill  = 0;
    hlt  = 0;
    take = 0;
    if (n < NREGS) r = m_regs[n];
    case (w[7:4])
      4'h0: ;
      4'h1: loadAcc(imm);
      4'h2: setAcc(a + iv, (a + iv) > 255);
      4'h3: setAcc(a - iv, a < iv);
      4'h4: setAcc(a & iv, 1'b0);
      4'h5: setAcc(a | iv, 1'b0);
      4'h6: setAcc(a ^ iv, 1'b0);
      4'h7: if (n < NREGS) m_regs[n] = m_ac; else ill = 1;
      4'h8: if (n < NREGS) loadAcc(r[7:0]); else ill = 1;
      4'h9: if (n < NREGS) setAcc(a + r, (a + r) > 255); else ill = 1;
      4'hA: if (n < NREGS) setAcc(a - r, a < r); else ill = 1;
      4'hB: begin
        case (n)
          0: setAcc(255 - a, 1'b0);
          1: setAcc(a * 2, a >= 128);
          2: setAcc(a / 2, (a % 2) == 1);
          3: setAcc(a + 1, a == 255);
          4: setAcc(a - 1, a == 0);
          default: ill = 1;
        endcase
      end
      4'hC: begin
        case (n)
          0: take = 1;
          1: take = m_z;
          2: take = !m_z;
          3: take = m_c;
          4: take = !m_c;
          default: ill = 1;
        endcase
      end
      4'hF: hlt = 1;
      default: ill = 1;
    endcase
    if (ill) begin
      m_err = 1'b1;
      hlt   = 1;
    end
    if (hlt) begin
      m_run  = 1'b0;
      m_halt = 1'b1;
    end else begin
      if (take) m_pc = imm[4:0];
      if (s_mode) begin
        m_run   = 1'b0;
        m_stall = 1'b1;
      end
    end
  endtask

  task automatic modelStep();
    if (s_rst) begin
      m_pc = 5'd0; m_ac = 8'h00; m_z = 1'b0; m_c = 1'b0; m_err = 1'b0;
      m_run = 1'b0; m_halt = 1'b0; m_stall = 1'b0; m_phase = 0; m_len = 2;
      for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    end else if (m_run) begin
      if (m_phase == 0) begin
        m_ipc = m_pc;
        m_len = twoWord(mem[m_pc][7:4]) ? 3 : 2;
      end
      if (m_phase < m_len - 1) begin
        m_pc    = m_pc + 5'd1;
        m_phase = m_phase + 1;
      end else begin
        m_phase = 0;
        execute();
      end
    end else if (m_stall) begin
      if (s_step || !s_mode) begin
        m_stall = 1'b0;
        m_run   = 1'b1;
      end
    end else begin
      if (s_we) mem[s_addr] = s_data;
      if (s_start) begin
        m_pc   = 5'd0;
        m_err  = 1'b0;
        m_halt = 1'b0;
        if (s_mode) m_stall = 1'b1;
        else m_run = 1'b1;
      end
    end
  endtask

  // Every cycle the visible outputs must match the reference machine.
  initial begin
    logic [17:0] act, expv;
    @(posedge clk);
    forever begin
      @(negedge clk);
      modelStep();
      expv = {m_run, m_halt, m_err, m_ac, m_pc, m_z, m_c};
      act  = {busy, halted, err, acc_out, pc_out, flag_z, flag_c};
      checks = checks + 1;
      if (act !== expv) begin
        errors = errors + 1;
        $display("[TB] FAIL model_cycle t=%0t {busy,halted,err,acc,pc,z,c} actual=%h required=%h",
                 $time, act, expv);
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks = checks + 1;
    if (actual != expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic loadWord(input int a, input int d);
    prog_we   = 1'b1;
    prog_addr = a[4:0];
    prog_data = d[7:0];
    @(negedge clk);
    prog_we   = 1'b0;
  endtask

  task automatic applyStimulus(output int cyc);
    int guard;
    cyc   = 0;
    guard = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!halted && guard < 1000) begin
      if (busy) cyc++;
      guard++;
      @(negedge clk);
    end
    checkOutput("run_reaches_halt", halted, 1);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    step = 1'b0; step_mode = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_acc", acc_out, 8'h00);
    checkOutput("reset_busy_halted_err", {busy, halted, err}, 0);
    checkOutput("reset_pc", pc_out, 0);
    rst = 1'b0;
    @(negedge clk);

    // LDI 5 ; ADDI 0xFB ; HALT
    loadWord(0, 8'h10); loadWord(1, 8'h05); loadWord(2, 8'h20); loadWord(3, 8'hFB); loadWord(4, 8'hF0);
    applyStimulus(cyc);
    checkOutput("add_busy_cycles", cyc, 8);
    checkOutput("add_acc", acc_out, 8'h00);
    checkOutput("add_z", flag_z, 1);
    checkOutput("add_c", flag_c, 1);

    // LDI 3 ; loop: DEC ; JNZ 2 ; HALT
    loadWord(0, 8'h10); loadWord(1, 8'h03); loadWord(2, 8'hB4);
    loadWord(3, 8'hC2); loadWord(4, 8'h02); loadWord(5, 8'hF0);
    applyStimulus(cyc);
    checkOutput("loop_busy_cycles", cyc, 20);
    checkOutput("loop_acc", acc_out, 8'h00);
    checkOutput("loop_z", flag_z, 1);
    checkOutput("loop_c", flag_c, 0);

    // LDI 0x12 ; MOV R1 ; LDI 0x30 ; ADD R1 ; HALT
    loadWord(0, 8'h10); loadWord(1, 8'h12); loadWord(2, 8'h71); loadWord(3, 8'h10);
    loadWord(4, 8'h30); loadWord(5, 8'h91); loadWord(6, 8'hF0);
    applyStimulus(cyc);
    checkOutput("reg_add_acc", acc_out, 8'h42);
    checkOutput("reg_add_err", err, 0);

    // MOV R7 is out of range for four registers and must trap.
    loadWord(0, 8'h77); loadWord(1, 8'hF0);
    applyStimulus(cyc);
    checkOutput("illegal_err", err, 1);
    checkOutput("illegal_halted", halted, 1);
    checkOutput("illegal_acc_kept", acc_out, 8'h42);
    checkOutput("illegal_busy_cycles", cyc, 2);

    // LDI 0xFF ; HALT, then JNZ 31 / NOT at 31 wrapping back to address 0.
    loadWord(0, 8'h10); loadWord(1, 8'hFF); loadWord(2, 8'hF0);
    applyStimulus(cyc);
    checkOutput("err_cleared_by_start", err, 0);
    checkOutput("preload_acc", acc_out, 8'hFF);
    loadWord(0, 8'hC2); loadWord(1, 8'h1F); loadWord(31, 8'hB0);
    applyStimulus(cyc);
    checkOutput("wrap_busy_cycles", cyc, 10);
    checkOutput("wrap_pc", pc_out, 3);
    checkOutput("wrap_acc", acc_out, 8'h00);
    checkOutput("wrap_z", flag_z, 1);

    // LDI 7 ; NOP ; INC ; HALT with an attempted overwrite of address 3 while busy.
    loadWord(0, 8'h10); loadWord(1, 8'h07); loadWord(2, 8'h00); loadWord(3, 8'hB3); loadWord(4, 8'hF0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; prog_we = 1'b1; prog_addr = 5'd3; prog_data = 8'hF0;
    repeat (4) @(negedge clk);
    prog_we = 1'b0;
    cyc = 0;
    while (!halted && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    checkOutput("busy_write_ignored_acc", acc_out, 8'h08);
    checkOutput("busy_write_ignored_pc", pc_out, 5);

    // Reset while the first instruction is in EXEC.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("pre_reset_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid_reset_acc", acc_out, 8'h00);
    checkOutput("mid_reset_busy_halted", {busy, halted}, 0);
    checkOutput("mid_reset_pc", pc_out, 0);

    // Write and start in the same cycle: the new word is the first one fetched.
    prog_we = 1'b1; prog_addr = 5'd0; prog_data = 8'hF0; start = 1'b1;
    @(negedge clk);
    prog_we = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("same_cycle_halted", halted, 1);
    checkOutput("same_cycle_pc", pc_out, 1);

    // Reset wins over a simultaneous start.
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checkOutput("rst_over_start", {busy, halted}, 0);

`ifdef ACC_CPU_STEP_EN
    // LDI 3 ; INC ; INC ; HALT, one instruction per step pulse.
    loadWord(0, 8'h10); loadWord(1, 8'h03); loadWord(2, 8'hB3); loadWord(3, 8'hB3); loadWord(4, 8'hF0);
    step_mode = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("step_wait_busy", busy, 0);
    checkOutput("step_wait_pc", pc_out, 0);
    for (int k = 0; k < 4; k++) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("step_pc", pc_out, (k == 0) ? 2 : k + 2);
      checkOutput("step_busy_low", busy, 0);
    end
    checkOutput("step_acc", acc_out, 8'h05);
    checkOutput("step_halted", halted, 1);
    step_mode = 1'b0;
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
